// File: rtl/mac_feeder.sv
// mac_feeder
// Sequencer stage in front of a single registered MAC cell. A job of K
// data/weight pairs is requested with start/len. The MAC is cleared for one
// cycle, each pair is then presented with mac_control asserted, and the final
// accumulator value is returned on a valid/ready result port.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start, len          job request and pair count (sampled in IDLE only)
//   busy                high whenever the sequencer is not idle
//   in_valid/in_ready   operand stream handshake, in_data/in_wt operands
//   mac_data, mac_wt    registered operands to the MAC
//   mac_control         registered MAC accumulate enable
//   mac_clear           MAC synchronous clear (decoded from state)
//   mac_acc             MAC accumulator output
//   res_valid/res_ready result handshake, res_data registered dot product
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_wt,
  output logic [DATA_WIDTH-1:0] mac_data,
  output logic [DATA_WIDTH-1:0] mac_wt,
  output logic                  mac_control,
  output logic                  mac_clear,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [LEN_WIDTH-1:0]  remaining_next_s;
  logic [DATA_WIDTH-1:0] data_next_s;
  logic [DATA_WIDTH-1:0] wt_next_s;
  logic                  control_next_s;
  logic [ACC_WIDTH-1:0]  res_next_s;
  logic                  take_s;

  // in_ready is registered as "state is RUN", so a transfer is RUN && in_valid.
  assign take_s = (state_r == S_RUN) && in_valid;

  // The MAC clear is the only output decoded straight from the state.
  assign mac_clear = (state_r == S_CLEAR);

  // Next-state and next-output decode.
  always_comb begin
    state_next_s     = state_r;
    remaining_next_s = remaining_r;
    data_next_s      = mac_data;
    wt_next_s        = mac_wt;
    control_next_s   = 1'b0;
    res_next_s       = res_data;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          remaining_next_s = len;
          state_next_s     = S_CLEAR;
        end else begin
          state_next_s     = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (remaining_r != {LEN_WIDTH{1'b0}}) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_DRAIN1;
        end
      end
      S_RUN: begin
        if (take_s) begin
          data_next_s      = in_data;
          wt_next_s        = in_wt;
          control_next_s   = 1'b1;
          remaining_next_s = remaining_r - LEN_WIDTH'(1);
          if (remaining_r == LEN_WIDTH'(1)) begin
            state_next_s = S_DRAIN1;
          end else begin
            state_next_s = S_RUN;
          end
        end else begin
          // No transfer: operands hold, MAC holds through its feedback path.
          control_next_s = 1'b0;
        end
      end
      S_DRAIN1: begin
        // The last pair is being accumulated by the MAC during this cycle.
        state_next_s = S_DRAIN2;
      end
      S_DRAIN2: begin
        // MAC output now includes the final pair.
        res_next_s   = mac_acc;
        state_next_s = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_RESULT;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State, job counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      remaining_r <= {LEN_WIDTH{1'b0}};
      mac_data    <= {DATA_WIDTH{1'b0}};
      mac_wt      <= {DATA_WIDTH{1'b0}};
      mac_control <= 1'b0;
      res_data    <= {ACC_WIDTH{1'b0}};
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      remaining_r <= remaining_next_s;
      mac_data    <= data_next_s;
      mac_wt      <= wt_next_s;
      mac_control <= control_next_s;
      res_data    <= res_next_s;
      busy        <= (state_next_s != S_IDLE);
      in_ready    <= (state_next_s == S_RUN);
      res_valid   <= (state_next_s == S_RESULT);
    end
  end

endmodule
